// File: rtl/move_sequencer_pkg.sv
// Shared types and constants for the robot motion sequencer.
package move_pkg;

  localparam int MV_CODE_W = 3;

  // Motion codes stored in the upper bits of each program step word.
  typedef enum logic [MV_CODE_W-1:0] {
    MV_STOP  = 3'd0,
    MV_FWD   = 3'd1,
    MV_REV   = 3'd2,
    MV_LEFT  = 3'd3,
    MV_RIGHT = 3'd4
  } mv_code_t;

  // H-bridge enables, ordered {l_fwd, l_rev, r_fwd, r_rev}.
  localparam logic [3:0] MOTOR_OFF   = 4'b0000;
  localparam logic [3:0] MOTOR_FWD   = 4'b1010;
  localparam logic [3:0] MOTOR_REV   = 4'b0101;
  localparam logic [3:0] MOTOR_LEFT  = 4'b0110;
  localparam logic [3:0] MOTOR_RIGHT = 4'b1001;

  // Step word layout: {code[MV_CODE_W-1:0], dur[DUR_W-1:0]}.

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_RUN  = 3'd2,
    ST_HOLD = 3'd3,
    ST_DONE = 3'd4
  } seq_state_t;

  // STOP and undefined codes leave every bridge leg disabled.
  function automatic logic [3:0] motor_decode(input logic [MV_CODE_W-1:0] code);
    logic [3:0] m;
    case (code)
      MV_FWD:   m = MOTOR_FWD;
      MV_REV:   m = MOTOR_REV;
      MV_LEFT:  m = MOTOR_LEFT;
      MV_RIGHT: m = MOTOR_RIGHT;
      default:  m = MOTOR_OFF;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/move_sequencer_if.sv
// Control/status bundle between the sequencer and its environment.
interface move_sequencer_if #(
  parameter int STEP_W = 2,
  parameter int DUR_W  = 4
);
  logic              sec_toggle;
  logic              start;
  logic              stop;
  logic              obstacle;
  logic [3:0]        motor;
  logic              busy;
  logic              done;
  logic [STEP_W-1:0] step_idx;
  logic [DUR_W-1:0]  secs_left;

  modport master (
    output sec_toggle, start, stop, obstacle,
    input  motor, busy, done, step_idx, secs_left
  );

  modport slave (
    input  sec_toggle, start, stop, obstacle,
    output motor, busy, done, step_idx, secs_left
  );
endinterface

// File: rtl/move_sequencer_rom.sv
// Fixed motion program: step index -> {code, duration} word.
module move_rom
  import move_pkg::*;
#(
  parameter int NUM_STEPS = 4,
  parameter int STEP_W    = 2,
  parameter int DUR_W     = 4
) (
  input  logic [STEP_W-1:0]          step_idx,
  output logic [MV_CODE_W+DUR_W-1:0] word
);

  // Out-of-range indices read as a zero-length STOP step.
  always_comb begin
    word = '0;
    if (int'(step_idx) < NUM_STEPS) begin
      case (int'(step_idx))
        0:       word = {MV_FWD,   DUR_W'(3)};
        1:       word = {MV_RIGHT, DUR_W'(1)};
        2:       word = {MV_STOP,  DUR_W'(0)};
        3:       word = {MV_REV,   DUR_W'(2)};
        default: word = '0;
      endcase
    end
  end

endmodule

// File: rtl/move_sequencer.sv
// Plays the motion program one step at a time, timed by the 1 Hz toggle.
module move_sequencer
  import move_pkg::*;
#(
  parameter int NUM_STEPS = 4,
  parameter int STEP_W    = 2,
  parameter int DUR_W     = 4
) (
  input  logic           clk,
  input  logic           reset,
  move_sequencer_if.slave bus
);

  localparam int              WORD_W    = MV_CODE_W + DUR_W;
  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(NUM_STEPS - 1);

  seq_state_t             state_q, state_d;
  logic [STEP_W-1:0]      step_idx_q, step_idx_d;
  logic [DUR_W-1:0]       secs_left_q, secs_left_d;
  logic [3:0]             motor_q, motor_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   sec_q, sec_d;

  logic [WORD_W-1:0]      step_word;
  logic [MV_CODE_W-1:0]   step_code;
  logic [DUR_W-1:0]       step_dur;
  logic                   tick;
  logic                   last_step;
  logic                   fwd_blocked;

  move_rom #(
    .NUM_STEPS (NUM_STEPS),
    .STEP_W    (STEP_W),
    .DUR_W     (DUR_W)
  ) u_rom (
    .step_idx (step_idx_q),
    .word     (step_word)
  );

  assign step_code   = step_word[WORD_W-1 -: MV_CODE_W];
  assign step_dur    = step_word[DUR_W-1:0];
  assign tick        = bus.sec_toggle ^ sec_q;
  assign last_step   = (step_idx_q == LAST_STEP);
  assign fwd_blocked = bus.obstacle && (step_code == MV_FWD);

  // Next-state, step/second bookkeeping and registered output decode.
  // Outputs are decoded from state_d so they line up with the state register;
  // step_idx never changes on entry to RUN, so step_code is already correct.
  always_comb begin
    state_d     = state_q;
    step_idx_d  = step_idx_q;
    secs_left_d = secs_left_q;
    sec_d       = bus.sec_toggle;

    if (bus.stop) begin
      state_d     = ST_IDLE;
      step_idx_d  = '0;
      secs_left_d = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.start) begin
            state_d    = ST_LOAD;
            step_idx_d = '0;
          end
        end
        ST_LOAD: begin
          secs_left_d = step_dur;
          if (step_dur == '0) begin
            if (last_step) state_d = ST_DONE;
            else           step_idx_d = step_idx_q + STEP_W'(1);
          end else begin
            state_d = ST_RUN;
          end
        end
        ST_RUN: begin
          if (fwd_blocked) begin
            state_d = ST_HOLD;
          end else if (tick) begin
            if (secs_left_q > DUR_W'(1)) begin
              secs_left_d = secs_left_q - DUR_W'(1);
            end else if (last_step) begin
              state_d = ST_DONE;
            end else begin
              state_d    = ST_LOAD;
              step_idx_d = step_idx_q + STEP_W'(1);
            end
          end
        end
        ST_HOLD: begin
          if (!bus.obstacle) state_d = ST_RUN;
        end
        ST_DONE: begin
          state_d     = ST_IDLE;
          step_idx_d  = '0;
          secs_left_d = '0;
        end
        default: begin
          state_d     = ST_IDLE;
          step_idx_d  = '0;
          secs_left_d = '0;
        end
      endcase
    end

    motor_d = (state_d == ST_RUN) ? motor_decode(step_code) : MOTOR_OFF;
    busy_d  = (state_d == ST_LOAD) || (state_d == ST_RUN) || (state_d == ST_HOLD);
    done_d  = (state_d == ST_DONE);
  end

  // State and output registers; sec_q tracks the toggle even in reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      step_idx_q  <= '0;
      secs_left_q <= '0;
      motor_q     <= MOTOR_OFF;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      sec_q       <= bus.sec_toggle;
    end else begin
      state_q     <= state_d;
      step_idx_q  <= step_idx_d;
      secs_left_q <= secs_left_d;
      motor_q     <= motor_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      sec_q       <= sec_d;
    end
  end

  assign bus.motor     = motor_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.step_idx  = step_idx_q;
  assign bus.secs_left = secs_left_q;

endmodule
